serial_frame_receiver: RTL and testbench



---
 rtl/serial_link_pkg.sv | 20 ++
 rtl/sync_ff.sv | 24 ++
 rtl/serial_frame_receiver.sv | 159 +++++++++++++++
 tb/tb_serial_frame_receiver.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_link_pkg.sv
// Shared definitions for the 4-bit UART-style serial link (receiver and transmitter).
package serial_link_pkg;

  localparam int unsigned FRAME_DATA_BITS = 4;

  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b1;

  typedef logic [FRAME_DATA_BITS-1:0] frame_data_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } link_state_e;

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flop synchronizer for an asynchronous single-bit input.
module sync_ff #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= {STAGES{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/serial_frame_receiver.sv
// Receives start/4-data/stop frames on SIN, samples mid-bit, and presents the
// nibble on held parallel outputs with single-cycle VALID / FRAME_ERR strobes.
module serial_frame_receiver
  import serial_link_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic SIN,
  output logic OUT1,
  output logic OUT2,
  output logic OUT3,
  output logic OUT4,
  output logic VALID,
  output logic FRAME_ERR,
  output logic BUSY
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF  = CLKS_PER_BIT / 2;
  localparam int unsigned IDX_W = $clog2(FRAME_DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_DATA_BITS - 1);

  link_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]  r_idx, w_idx_nxt;
  frame_data_t       r_shift, w_shift_nxt;
  frame_data_t       r_data, w_data_nxt;
  logic              r_valid, w_valid_nxt;
  logic              r_ferr, w_ferr_nxt;
  logic              r_busy;
  logic              w_s_in;
  logic              w_bit_end;

  sync_ff #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (IDLE_LEVEL)
  ) u_sync (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_d     (SIN),
    .o_q     (w_s_in)
  );

  assign w_bit_end = (r_cnt == CNT_LAST);

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_ferr  <= w_ferr_nxt;
      r_busy  <= (w_state_nxt != IDLE);
    end
  end

  // Next-state, bit timing and capture logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_valid_nxt = 1'b0;
    w_ferr_nxt  = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_s_in == START_LEVEL) begin
          w_state_nxt = START;
          w_cnt_nxt   = '0;
        end
      end

      START: begin
        if (r_cnt == CNT_MID) begin
          w_cnt_nxt = '0;
          if (w_s_in == START_LEVEL) begin
            w_state_nxt = DATA;
            w_idx_nxt   = '0;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      DATA: begin
        if (w_bit_end) begin
          w_shift_nxt[r_idx] = w_s_in;
          w_cnt_nxt          = '0;
          w_idx_nxt          = r_idx + IDX_W'(1);
          if (r_idx == IDX_LAST) begin
            w_state_nxt = STOP;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      STOP: begin
        if (w_bit_end) begin
          w_cnt_nxt = '0;
          if (w_s_in == STOP_LEVEL) begin
            w_data_nxt  = r_shift;
            w_valid_nxt = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_ferr_nxt  = 1'b1;
            w_state_nxt = WAIT_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      // A held-low break must release before another start bit is accepted.
      WAIT_IDLE: begin
        if (w_s_in == IDLE_LEVEL) begin
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        w_idx_nxt   = '0;
      end
    endcase
  end

  assign OUT1      = r_data[0];
  assign OUT2      = r_data[1];
  assign OUT3      = r_data[2];
  assign OUT4      = r_data[3];
  assign VALID     = r_valid;
  assign FRAME_ERR = r_ferr;
  assign BUSY      = r_busy;

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed bench for serial_frame_receiver: a frame table plus hand-written
// sequences for latency, glitch, break, back-to-back and mid-frame reset.
module tb_serial_frame_receiver;

  localparam int unsigned CPB  = 4;
  localparam int unsigned SYNC = 2;

  logic CLK;
  logic RST_N;
  logic SIN;
  logic OUT1, OUT2, OUT3, OUT4;
  logic VALID, FRAME_ERR, BUSY;
  logic [3:0] w_out;

  serial_frame_receiver #(
    .CLKS_PER_BIT (CPB),
    .SYNC_STAGES  (SYNC)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .SIN       (SIN),
    .OUT1      (OUT1),
    .OUT2      (OUT2),
    .OUT3      (OUT3),
    .OUT4      (OUT4),
    .VALID     (VALID),
    .FRAME_ERR (FRAME_ERR),
    .BUSY      (BUSY)
  );

  assign w_out = {OUT4, OUT3, OUT2, OUT1};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fall_cyc = 0;

  int valid_cnt = 0;
  int ferr_cnt = 0;
  int last_valid_cyc = 0;
  int prev_valid_cyc = 0;
  logic [3:0] last_valid_data = '0;
  logic [3:0] prev_valid_data = '0;
  logic busy_at_valid = 1'b0;
  logic busy_before_valid = 1'b0;
  logic prev_busy = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pulse monitor, sampled on the falling edge.
  always @(negedge CLK) begin
    if (VALID || FRAME_ERR) begin
      check("valid_ferr_exclusive", int'(VALID && FRAME_ERR), 0);
    end
    if (VALID) begin
      valid_cnt++;
      prev_valid_cyc    = last_valid_cyc;
      last_valid_cyc    = cyc;
      prev_valid_data   = last_valid_data;
      last_valid_data   = w_out;
      busy_at_valid     = BUSY;
      busy_before_valid = prev_busy;
    end
    if (FRAME_ERR) ferr_cnt++;
    prev_busy = BUSY;
  end

  // Caller must be at a falling edge; returns at the falling edge ending the stop bit.
  task automatic send_frame(input logic [3:0] d, input logic stop);
    SIN = 1'b0;
    fall_cyc = cyc;
    for (int i = 0; i < 4; i++) begin
      repeat (CPB) @(negedge CLK);
      SIN = d[i];
    end
    repeat (CPB) @(negedge CLK);
    SIN = stop;
    repeat (CPB) @(negedge CLK);
  endtask

  task automatic idle(input int n);
    SIN = 1'b1;
    repeat (n) @(negedge CLK);
  endtask

  typedef struct {
    logic [3:0] data;
    logic       stop;
    int         exp_valid;
    int         exp_ferr;
    logic [3:0] exp_out;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int v0, f0;
    logic seen;

    vecs[0] = '{data: 4'b1101, stop: 1'b1, exp_valid: 1, exp_ferr: 0, exp_out: 4'b1101};
    vecs[1] = '{data: 4'b0000, stop: 1'b1, exp_valid: 1, exp_ferr: 0, exp_out: 4'b0000};
    vecs[2] = '{data: 4'b1111, stop: 1'b1, exp_valid: 1, exp_ferr: 0, exp_out: 4'b1111};
    vecs[3] = '{data: 4'b1010, stop: 1'b1, exp_valid: 1, exp_ferr: 0, exp_out: 4'b1010};
    vecs[4] = '{data: 4'b0101, stop: 1'b0, exp_valid: 0, exp_ferr: 1, exp_out: 4'b1010};
    vecs[5] = '{data: 4'b0011, stop: 1'b1, exp_valid: 1, exp_ferr: 0, exp_out: 4'b0011};

    // Reset with the line idle.
    RST_N = 1'b0;
    SIN   = 1'b1;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    check("reset_out", int'(w_out), 0);
    check("reset_valid", int'(VALID), 0);
    check("reset_ferr", int'(FRAME_ERR), 0);
    check("reset_busy", int'(BUSY), 0);
    check("reset_pulses", valid_cnt + ferr_cnt, 0);

    // Good frame 1,0,1,1 (bit 0 first): latency and BUSY alignment.
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(4'b1101, 1'b1);
    idle(8);
    check("frame1_valid_count", valid_cnt - v0, 1);
    check("frame1_ferr_count", ferr_cnt - f0, 0);
    check("frame1_out", int'(w_out), 4'b1101);
    check("frame1_latency", last_valid_cyc - fall_cyc, 25);
    check("frame1_busy_low_at_valid", int'(busy_at_valid), 0);
    check("frame1_busy_high_before", int'(busy_before_valid), 1);

    // One-cycle glitch: START aborts back to IDLE.
    v0 = valid_cnt; f0 = ferr_cnt;
    SIN = 1'b0;
    @(negedge CLK);
    SIN = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (BUSY) seen = 1'b1;
    end
    check("glitch_busy_seen", int'(seen), 1);
    check("glitch_busy_end", int'(BUSY), 0);
    check("glitch_valid", valid_cnt - v0, 0);
    check("glitch_ferr", ferr_cnt - f0, 0);
    check("glitch_out", int'(w_out), 4'b1101);

    // Bad stop bit followed by a 40-cycle break.
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(4'b0110, 1'b0);
    repeat (40) @(negedge CLK);
    check("break_ferr", ferr_cnt - f0, 1);
    check("break_valid", valid_cnt - v0, 0);
    check("break_busy_held", int'(BUSY), 1);
    check("break_out", int'(w_out), 4'b1101);
    idle(8);
    check("break_busy_release", int'(BUSY), 0);

    // Back-to-back frames with no idle gap.
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(4'b0001, 1'b1);
    send_frame(4'b1110, 1'b1);
    idle(8);
    check("b2b_valid_count", valid_cnt - v0, 2);
    check("b2b_ferr_count", ferr_cnt - f0, 0);
    check("b2b_first_data", int'(prev_valid_data), 4'b0001);
    check("b2b_second_data", int'(last_valid_data), 4'b1110);
    check("b2b_gap", last_valid_cyc - prev_valid_cyc, 24);

    // Reset during DATA of frame 1111.
    SIN = 1'b0;
    repeat (CPB) @(negedge CLK);
    SIN = 1'b1;
    repeat (6) @(negedge CLK);
    check("rstmid_busy_before", int'(BUSY), 1);
    v0 = valid_cnt; f0 = ferr_cnt;
    RST_N = 1'b0;
    #1;
    check("rstmid_out_clear", int'(w_out), 0);
    check("rstmid_busy_clear", int'(BUSY), 0);
    check("rstmid_valid_clear", int'(VALID), 0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    idle(40);
    check("rstmid_no_valid", valid_cnt - v0, 0);
    check("rstmid_no_ferr", ferr_cnt - f0, 0);
    send_frame(4'b0101, 1'b1);
    idle(8);
    check("rstmid_fresh_valid", valid_cnt - v0, 1);
    check("rstmid_fresh_out", int'(w_out), 4'b0101);

    // Table of frames.
    for (int i = 0; i < 6; i++) begin
      v0 = valid_cnt; f0 = ferr_cnt;
      send_frame(vecs[i].data, vecs[i].stop);
      idle(8);
      check($sformatf("vec%0d_valid", i), valid_cnt - v0, vecs[i].exp_valid);
      check($sformatf("vec%0d_ferr", i), ferr_cnt - f0, vecs[i].exp_ferr);
      check($sformatf("vec%0d_out", i), int'(w_out), int'(vecs[i].exp_out));
      check($sformatf("vec%0d_busy", i), int'(BUSY), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
